// File: rtl/pll_clk_gen_pkg.sv
// -----------------------------------------------------------------------------
// pll_clk_gen_pkg
//   Shared constants for the behavioural PLL stand-in and for the clock/reset
//   block that consumes it.
//
//   SYS_CLK_DIV     : inclk0 -> system clock divide ratio
//   MEM_CLK_DIV     : inclk0 -> memory clock divide ratio
//   PLL_LOCK_CYCLES : inclk0 rising edges (after synchronised reset release)
//                     before lock is reported
//   PLL_CNT_W       : width of the lock counter
//   ceil_half()     : number of high cycles per period for a divide-by-n output
// -----------------------------------------------------------------------------
package pll_clk_gen_pkg;

    localparam int SYS_CLK_DIV     = 2;
    localparam int MEM_CLK_DIV     = 1;
    localparam int PLL_LOCK_CYCLES = 16;
    localparam int PLL_CNT_W       = 16;

    // Odd ratios spend the extra cycle high.
    function automatic int ceil_half(input int n);
        return (n + 1) / 2;
    endfunction

endpackage

// File: rtl/pll_clk_gen_clk_div_n.sv
// -----------------------------------------------------------------------------
// clk_div_n
//   Integer clock divider whose output is held low until en rises, then starts
//   from count 0 so that several instances sharing en stay phase aligned.
//
//   Ports:
//     clk    in   reference clock
//     rst_n  in   asynchronous active-low reset
//     en     in   start/run enable (the PLL lock flag)
//     clk_o  out  clk / N
//
//   N == 1 : clk gated by en re-timed on the falling edge, so the gate only
//            changes while clk is low and can never produce a runt pulse.
//   N >= 2 : registered output, high for ceil(N/2) cycles of every N.
// -----------------------------------------------------------------------------
module clk_div_n
    import pll_clk_gen_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic clk_o
);

    generate
        if (N < 1) begin : g_bad_ratio
            $fatal(1, "clk_div_n: N must be >= 1");
        end else if (N == 1) begin : g_pass
            logic en_fall_reg;

            always_ff @(negedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_fall_reg <= 1'b0;
                end else begin
                    en_fall_reg <= en;
                end
            end

            assign clk_o = clk & en_fall_reg;
        end else begin : g_div
            localparam int             W        = $clog2(N);
            localparam logic [W-1:0]   LAST     = W'(N - 1);
            localparam logic [W-1:0]   HIGH_CNT = W'(ceil_half(N));

            logic [W-1:0] cnt_reg;
            logic [W-1:0] cnt_next;
            logic         out_reg;
            logic         out_next;

            // Count 0 always produces a high output, so the first rise lands
            // on the first edge that sees en=1.
            always_comb begin
                cnt_next = '0;
                out_next = 1'b0;
                if (en) begin
                    out_next = (cnt_reg < HIGH_CNT);
                    cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                    out_reg <= 1'b0;
                end else begin
                    cnt_reg <= cnt_next;
                    out_reg <= out_next;
                end
            end

            assign clk_o = out_reg;
        end
    endgenerate

endmodule

// File: rtl/pll_clk_gen.sv
// -----------------------------------------------------------------------------
// pll_clk_gen
//   Synthesizable behavioural stand-in for the vendor PLL. Derives the system
//   clock (c0) and memory clock (c1) from the board clock by integer division
//   and reports lock after a fixed settling time.
//
//   Ports:
//     inclk0    in   board reference clock (only clock in the block)
//     areset_n  in   asynchronous active-low reset
//     c0        out  system clock  = inclk0 / C0_DIV
//     c1        out  memory clock  = inclk0 / C1_DIV
//     locked    out  c0/c1 running and phase aligned (sticky until reset)
//
//   Timing after areset_n release: the 2-flop synchroniser raises run on the
//   2nd inclk0 rising edge, locked rises on the LOCK_CYCLES-th edge with run=1,
//   and both dividers produce their first rising edge on the following edge.
// -----------------------------------------------------------------------------
module pll_clk_gen
    import pll_clk_gen_pkg::*;
#(
    parameter int C0_DIV      = SYS_CLK_DIV,
    parameter int C1_DIV      = MEM_CLK_DIV,
    parameter int LOCK_CYCLES = PLL_LOCK_CYCLES,
    parameter int CNT_W       = PLL_CNT_W
) (
    input  logic inclk0,
    input  logic areset_n,
    output logic c0,
    output logic c1,
    output logic locked
);

    generate
        if (C0_DIV < 1 || C1_DIV < 1) begin : g_bad_div
            $fatal(1, "pll_clk_gen: C0_DIV and C1_DIV must be >= 1");
        end
        if (LOCK_CYCLES < 1) begin : g_bad_lock
            $fatal(1, "pll_clk_gen: LOCK_CYCLES must be >= 1");
        end
        if ($clog2(LOCK_CYCLES + 1) > CNT_W) begin : g_bad_cnt_w
            $fatal(1, "pll_clk_gen: CNT_W too narrow for LOCK_CYCLES");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

    // -------------------------------------------------------------------------
    // Reset synchroniser: assertion is immediate, release is re-timed.
    // -------------------------------------------------------------------------
    logic [1:0] rst_sync_reg;
    logic       run;

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign run = rst_sync_reg[1];

    // -------------------------------------------------------------------------
    // Lock counter. The counter stops advancing once locked is set.
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] lock_cnt_reg;
    logic [CNT_W-1:0] lock_cnt_next;
    logic             locked_reg;
    logic             locked_next;

    always_comb begin
        lock_cnt_next = lock_cnt_reg;
        locked_next   = locked_reg;
        if (run && !locked_reg) begin
            lock_cnt_next = lock_cnt_reg + 1'b1;
            if (lock_cnt_reg == LOCK_LAST) begin
                locked_next = 1'b1;
            end
        end
    end

    always_ff @(posedge inclk0 or negedge areset_n) begin
        if (!areset_n) begin
            lock_cnt_reg <= '0;
            locked_reg   <= 1'b0;
        end else begin
            lock_cnt_reg <= lock_cnt_next;
            locked_reg   <= locked_next;
        end
    end

    assign locked = locked_reg;

    // -------------------------------------------------------------------------
    // Output dividers share the lock flag as their start enable, which is what
    // keeps their rising edges coincident for any ratio pair.
    // -------------------------------------------------------------------------
    clk_div_n #(
        .N (C0_DIV)
    ) u_div_c0 (
        .clk   (inclk0),
        .rst_n (areset_n),
        .en    (locked_reg),
        .clk_o (c0)
    );

    clk_div_n #(
        .N (C1_DIV)
    ) u_div_c1 (
        .clk   (inclk0),
        .rst_n (areset_n),
        .en    (locked_reg),
        .clk_o (c1)
    );

endmodule

// File: tb/tb_pll_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_pll_clk_gen
//   Directed bench for pll_clk_gen. Two instances share clock and reset:
//   u_dut_a with default ratios (c0 = /2, c1 = /1) and u_dut_b with
//   C0_DIV=3, C1_DIV=4. Outputs are sampled 1 ns after each inclk0 edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pll_clk_gen;

    localparam int LOCK_EDGES = 18;   // 2 synchroniser edges + 16 lock cycles

    logic inclk0;
    logic areset_n;
    logic clk_en;

    logic c0_a, c1_a, locked_a;
    logic c0_b, c1_b, locked_b;

    int n_checks;
    int n_fail;

    int rise_c0_a, rise_c1_a, rise_c0_b, rise_c1_b;

    pll_clk_gen u_dut_a (
        .inclk0   (inclk0),
        .areset_n (areset_n),
        .c0       (c0_a),
        .c1       (c1_a),
        .locked   (locked_a)
    );

    pll_clk_gen #(
        .C0_DIV      (3),
        .C1_DIV      (4),
        .LOCK_CYCLES (16),
        .CNT_W       (16)
    ) u_dut_b (
        .inclk0   (inclk0),
        .areset_n (areset_n),
        .c0       (c0_b),
        .c1       (c1_b),
        .locked   (locked_b)
    );

    // Gated 100 MHz clock; always stopped from the low phase.
    initial inclk0 = 1'b0;
    always begin
        #5;
        if (clk_en) inclk0 = ~inclk0;
    end

    initial begin
        rise_c0_a = 0; rise_c1_a = 0; rise_c0_b = 0; rise_c1_b = 0;
    end
    always @(posedge c0_a) rise_c0_a++;
    always @(posedge c1_a) rise_c1_a++;
    always @(posedge c0_b) rise_c0_b++;
    always @(posedge c1_b) rise_c1_b++;

    function automatic int total_rises();
        return rise_c0_a + rise_c1_a + rise_c0_b + rise_c1_b;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic wait_rise();
        @(posedge inclk0);
        #1;
    endtask

    task automatic wait_fall();
        @(negedge inclk0);
        #1;
    endtask

    function automatic logic [5:0] all_outs();
        return {c0_a, c1_a, locked_a, c0_b, c1_b, locked_b};
    endfunction

    // Expects reset to have just been released; walks the 18 lock edges.
    task automatic run_lock(input string tag);
        int base;
        base = total_rises();
        for (int k = 1; k <= LOCK_EDGES; k++) begin
            wait_rise();
            check_eq({tag, "_locked"}, {30'd0, locked_a, locked_b},
                     (k == LOCK_EDGES) ? 32'd3 : 32'd0);
            check_eq({tag, "_clk_quiet"}, {28'd0, c0_a, c1_a, c0_b, c1_b}, 32'd0);
        end
        wait_fall();
        check_eq({tag, "_clk_quiet_fall"}, {28'd0, c0_a, c1_a, c0_b, c1_b}, 32'd0);
        check_eq({tag, "_no_rises"}, total_rises() - base, 32'd0);
        $display("%s: lock sequence done, locked=%b/%b at t=%0t", tag, locked_a, locked_b, $time);
    endtask

    // Called right after run_lock: cycle j=1 is the first edge after lock.
    task automatic run_pattern(input string tag, input int n_cyc);
        int b_c0a, b_c1a, b_c0b, b_c1b;
        logic e_c0a, e_c0b, e_c1b;
        b_c0a = rise_c0_a; b_c1a = rise_c1_a; b_c0b = rise_c0_b; b_c1b = rise_c1_b;
        for (int j = 1; j <= n_cyc; j++) begin
            e_c0a = (j % 2) == 1;
            e_c0b = ((j - 1) % 3) < 2;
            e_c1b = ((j - 1) % 4) < 2;
            wait_rise();
            check_eq({tag, "_rise_a"}, {30'd0, c0_a, c1_a}, {30'd0, e_c0a, 1'b1});
            check_eq({tag, "_rise_b"}, {30'd0, c0_b, c1_b}, {30'd0, e_c0b, e_c1b});
            wait_fall();
            check_eq({tag, "_fall_a"}, {30'd0, c0_a, c1_a}, {30'd0, e_c0a, 1'b0});
            check_eq({tag, "_fall_b"}, {30'd0, c0_b, c1_b}, {30'd0, e_c0b, e_c1b});
        end
        check_eq({tag, "_c0a_rises"}, rise_c0_a - b_c0a, (n_cyc + 1) / 2);
        check_eq({tag, "_c1a_rises"}, rise_c1_a - b_c1a, n_cyc);
        check_eq({tag, "_c0b_rises"}, rise_c0_b - b_c0b, (n_cyc + 2) / 3);
        check_eq({tag, "_c1b_rises"}, rise_c1_b - b_c1b, (n_cyc + 3) / 4);
        $display("%s: %0d post-lock cycles checked", tag, n_cyc);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        n_checks = 0;
        n_fail   = 0;
        areset_n = 1'b0;
        clk_en   = 1'b1;

        // Reset held with the clock running.
        for (int i = 0; i < 20; i++) begin
            wait_rise();
            check_eq("rst_hold_rise", {26'd0, all_outs()}, 32'd0);
            wait_fall();
            check_eq("rst_hold_fall", {26'd0, all_outs()}, 32'd0);
        end
        $display("reset hold: 20 cycles with outputs low");

        #2 areset_n = 1'b1;
        run_lock("lock1");
        run_pattern("pat1", 12);

        // Asynchronous reset pulse in the high phase of inclk0.
        wait_rise();
        check_eq("pre_areset", {28'd0, c0_a, c1_a, locked_a, locked_b}, 32'hf);
        #2 areset_n = 1'b0;
        #1;
        check_eq("async_clear", {26'd0, all_outs()}, 32'd0);
        areset_n = 1'b1;
        $display("mid-run reset pulse: outputs cleared before next edge");
        run_lock("lock2");
        run_pattern("pat2", 8);

        // Reset released while the clock is stopped.
        clk_en = 1'b0;
        areset_n = 1'b0;
        #3 areset_n = 1'b1;
        base = total_rises();
        #100;
        check_eq("stopped_outs", {26'd0, all_outs()}, 32'd0);
        check_eq("stopped_rises", total_rises() - base, 32'd0);
        $display("clock stopped: no activity after reset release");
        clk_en = 1'b1;
        run_lock("lock3");
        run_pattern("pat3", 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
